// File: rtl/note_index_encoder.sv
// note_index_encoder
// Packs octave + note-within-octave (+ signed transpose) into a 6-bit linear
// note index: index = oct*12 + note + transpose. Multi-cycle, one request in
// flight at a time, valid/ready on both sides. Out-of-range requests are
// flagged with out_err and a zero index instead of wrapping.
module note_index_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_oct,
    input  logic [3:0] in_note,
    input  logic [4:0] in_transpose,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_index,
    output logic       out_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL8 = 3'd1,
        ADD4 = 3'd2,
        FIN  = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t            state_reg;
    logic [2:0]        oct_reg;
    logic [3:0]        note_reg;
    logic [4:0]        transpose_reg;
    // Range is -16..+114, so 9 signed bits never overflow.
    logic signed [8:0] acc_reg;

    logic signed [8:0] sum_next;
    logic              err_next;

    // Handshake-side status: in_ready is forced low during reset so no
    // request can appear accepted on a reset edge.
    assign in_ready = (state_reg == IDLE) && !rst;
    assign busy     = (state_reg != IDLE);

    // Final sum and range check used in FIN.
    always_comb begin
        sum_next = acc_reg
                 + $signed({5'b00000, note_reg})
                 + $signed({{4{transpose_reg[4]}}, transpose_reg});
        err_next = (note_reg > 4'd11) || (sum_next < 9'sd0) || (sum_next > 9'sd63);
    end

    // Control FSM and datapath; x12 is built as x8 then +x4 over two cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            oct_reg       <= 3'd0;
            note_reg      <= 4'd0;
            transpose_reg <= 5'd0;
            acc_reg       <= 9'sd0;
            out_valid     <= 1'b0;
            out_index     <= 6'd0;
            out_err       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        oct_reg       <= in_oct;
                        note_reg      <= in_note;
                        transpose_reg <= in_transpose;
                        state_reg     <= MUL8;
                    end
                end
                MUL8: begin
                    acc_reg   <= $signed({3'b000, oct_reg, 3'b000});
                    state_reg <= ADD4;
                end
                ADD4: begin
                    acc_reg   <= acc_reg + $signed({4'b0000, oct_reg, 2'b00});
                    state_reg <= FIN;
                end
                FIN: begin
                    if (err_next) begin
                        out_err   <= 1'b1;
                        out_index <= 6'd0;
                    end else begin
                        out_err   <= 1'b0;
                        out_index <= sum_next[5:0];
                    end
                    out_valid <= 1'b1;
                    state_reg <= OUT;
                end
                OUT: begin
                    // Result is held until accepted; index/err persist afterwards.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_index_encoder.sv
// Scoreboard bench for note_index_encoder: stimulus pushes expected results
// on each accepted request, a separate monitor pops and compares on every
// output handshake.
module tb_note_index_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_oct;
    logic [3:0] in_note;
    logic [4:0] in_transpose;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_index;
    logic       out_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct {
        logic [5:0] idx;
        logic       err;
        int         acc_cycle;
    } exp_t;

    exp_t exp_q[$];
    int   pushed = 0;
    int   popped = 0;
    int   last_accept;

    note_index_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_oct       (in_oct),
        .in_note      (in_note),
        .in_transpose (in_transpose),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .out_err      (out_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Present one request and wait (bounded) for acceptance; pushes the
    // expected result on the accepting edge.
    task automatic send(input logic [2:0] oct, input logic [3:0] note, input logic [4:0] tr,
                        input logic [5:0] eidx, input logic eerr, input bit keep_valid);
        exp_t e;
        bit   ok = 0;
        in_oct       = oct;
        in_note      = note;
        in_transpose = tr;
        in_valid     = 1'b1;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.idx       = eidx;
                e.err       = eerr;
                e.acc_cycle = cycle + 1;
                last_accept = cycle + 1;
                exp_q.push_back(e);
                pushed++;
                ok = 1;
                @(posedge clk);
                #1;
                if (!keep_valid) in_valid = 1'b0;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    // Monitor: compares every output handshake against the scoreboard.
    initial begin : monitor
        exp_t e;
        bit   prev_valid = 0;
        int   rise_cycle = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 0;
            end else begin
                if (out_valid && !prev_valid) rise_cycle = cycle;
                prev_valid = out_valid;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        popped++;
                        check("out_index", int'(out_index), int'(e.idx));
                        check("out_err", int'(out_err), int'(e.err));
                        check("latency", rise_cycle - e.acc_cycle, 3);
                    end
                end
            end
        end
    end

    initial begin : stim
        int prev_acc;
        logic       hold_valid;
        logic [5:0] hold_idx;
        logic       hold_err;
        bit         seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_oct = '0; in_note = '0; in_transpose = '0;
        @(negedge clk);
        check("in_ready_during_rst", int'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_index", int'(out_index), 0);
        check("rst_out_err", int'(out_err), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // Directed vectors with hand-computed results
        send(3'd4, 4'd9,  5'd0,  6'd57, 1'b0, 0);
        send(3'd5, 4'd3,  5'd0,  6'd63, 1'b0, 0);
        send(3'd5, 4'd4,  5'd0,  6'd0,  1'b1, 0);
        send(3'd0, 4'd12, 5'd0,  6'd0,  1'b1, 0);
        send(3'd1, 4'd0,  5'b11111, 6'd11, 1'b0, 0);
        send(3'd0, 4'd2,  5'b11101, 6'd0,  1'b1, 0);
        send(3'd3, 4'd11, 5'd15, 6'd62, 1'b0, 0);
        send(3'd7, 4'd0,  5'd0,  6'd0,  1'b1, 0);

        // Backpressure: 2*12+5+2 = 31
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b0;
        send(3'd2, 4'd5, 5'd2, 6'd31, 1'b0, 0);
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("bp_out_valid_seen", int'(seen), 1);
        hold_valid = out_valid; hold_idx = out_index; hold_err = out_err;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_oct = 3'(k); in_note = 4'(k); in_transpose = 5'(k * 3);
            @(negedge clk);
            check("bp_out_valid_hold", int'(out_valid), int'(hold_valid));
            check("bp_out_index_hold", int'(out_index), int'(hold_idx));
            check("bp_out_err_hold", int'(out_err), int'(hold_err));
            check("bp_in_ready_low", int'(in_ready), 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_before_hs", int'(out_valid), 1);
        @(negedge clk);
        check("bp_valid_after_hs", int'(out_valid), 0);
        check("bp_in_ready_back", int'(in_ready), 1);
        check("bp_index_persists", int'(out_index), 31);
        check("bp_queue_empty", exp_q.size(), 0);

        // Reset while in ADD4 (edge after E1); request must vanish.
        @(posedge clk); #1;
        in_oct = 3'd3; in_note = 4'd1; in_transpose = 5'd0; in_valid = 1'b1;
        @(negedge clk);
        check("rm_in_ready", int'(in_ready), 1);
        @(posedge clk); #1 in_valid = 1'b0;   // E0 -> MUL8
        @(posedge clk); #1 rst = 1'b1;        // E1 -> ADD4
        @(posedge clk); #1 rst = 1'b0;        // reset edge
        @(negedge clk);
        check("rm_busy", int'(busy), 0);
        check("rm_out_valid", int'(out_valid), 0);
        check("rm_out_index", int'(out_index), 0);
        check("rm_in_ready", int'(in_ready), 1);
        repeat (8) @(negedge clk);
        check("rm_no_output", int'(out_valid), 0);

        // Back-to-back: index i as oct=i/12, note=i%12, transpose=0
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) begin
            prev_acc = last_accept;
            send(3'(i / 12), 4'(i % 12), 5'd0, 6'(i), 1'b0, 1);
            if (i > 0) check("b2b_period", last_accept - prev_acc, 5);
        end
        in_valid = 1'b0;

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_handshakes", popped, pushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
